// File: rtl/bram_pkg.sv
// bram_pkg: shared sizing helpers, latency limits and address-range check for the block RAM family
package bram_pkg;

   localparam int RD_LATENCY_MIN = 1;
   localparam int RD_LATENCY_MAX = 4;

   // Bits needed to represent value (at least one bit)
   function automatic int clogb2(input int value);
      int bits;
      bits = 0;
      for (int v = value; v > 0; v = v >> 1) bits++;
      return (bits < 1) ? 1 : bits;
   endfunction

   // True when addr addresses an existing word of a depth-word array
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// bram_sdp_core: inferred simple-dual-port array with zeroed power-up contents and the first (array) read register
module bram_sdp_core
  import bram_pkg::*;
#(
  parameter int    WIDTH     = 18,
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  din,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    if (re) dout <= mem[raddr];
  end
endmodule

// File: rtl/bram_sdp_pipe.sv
// bram_sdp_pipe: simple-dual-port BRAM with 1..4 cycle pipelined read, valid tracking and sticky address error.
// Define BRAM_WRITE_FIRST_EN to make a same-address same-edge read return the incoming write data.
module bram_sdp_pipe
   import bram_pkg::*;
#(
   parameter int    RAM_WIDTH  = 18,
   parameter int    RAM_DEPTH  = 1024,
   parameter int    RD_LATENCY = 2,
   parameter string INIT_FILE  = "",
   localparam int   ADDR_W     = clogb2(RAM_DEPTH - 1)
) (
   input  logic                 clka,
   input  logic                 rsta_n,
   input  logic                 wea,
   input  logic [ADDR_W-1:0]    addra,
   input  logic [RAM_WIDTH-1:0] dina,
   input  logic                 enb,
   input  logic [ADDR_W-1:0]    addrb,
   output logic [RAM_WIDTH-1:0] doutb,
   output logic                 doutb_valid,
   output logic                 addr_err
);

   if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
      $error("bram_sdp_pipe: RD_LATENCY must be 1..4");
   end

   logic                  a_ok, b_ok, hit, zero_q, fwd_q;
   logic [RAM_WIDTH-1:0]  core_dout, fwd_data, stage0;
   logic [RD_LATENCY-1:0] vld;

   assign a_ok = addr_in_range(32'(addra), RAM_DEPTH);
   assign b_ok = addr_in_range(32'(addrb), RAM_DEPTH);

`ifdef BRAM_WRITE_FIRST_EN
   assign hit = wea && a_ok && (addra == addrb);
`else
   assign hit = 1'b0;
`endif

   bram_sdp_core #(
      .WIDTH     (RAM_WIDTH),
      .DEPTH     (RAM_DEPTH),
      .ADDR_W    (ADDR_W),
      .INIT_FILE (INIT_FILE)
   ) u_core (
      .clk   (clka),
      .we    (wea && a_ok && rsta_n),
      .waddr (addra),
      .din   (dina),
      .re    (enb && b_ok && rsta_n),
      .raddr (addrb),
      .dout  (core_dout)
   );

   // Side-band registered with the array read: zero an out-of-range or post-reset result, forward collisions
   always_ff @(posedge clka or negedge rsta_n)
      if (!rsta_n) begin
         zero_q   <= 1'b1;
         fwd_q    <= 1'b0;
         fwd_data <= '0;
      end else if (enb) begin
         zero_q   <= !b_ok;
         fwd_q    <= hit;
         fwd_data <= dina;
      end

   assign stage0 = zero_q ? '0 : fwd_q ? fwd_data : core_dout;

   // Valid shift register carrying each request down the read pipeline
   always_ff @(posedge clka or negedge rsta_n)
      if (!rsta_n) vld <= '0;
      else vld <= (vld << 1) | RD_LATENCY'(enb);

   if (RD_LATENCY == 1) begin : g_lat1
      assign doutb = stage0;
   end else begin : g_pipe
      logic [RAM_WIDTH-1:0] pipe [RD_LATENCY-1];
      // Output registers advance only behind valid data so doutb holds between responses
      always_ff @(posedge clka or negedge rsta_n)
         if (!rsta_n) begin
            for (int k = 0; k < RD_LATENCY - 1; k++) pipe[k] <= '0;
         end else begin
            if (vld[0]) pipe[0] <= stage0;
            for (int k = 1; k < RD_LATENCY - 1; k++) if (vld[k]) pipe[k] <= pipe[k-1];
         end
      assign doutb = pipe[RD_LATENCY-2];
   end

   assign doutb_valid = vld[RD_LATENCY-1];

   // Sticky flag for any enabled access outside the array
   always_ff @(posedge clka or negedge rsta_n)
      if (!rsta_n) addr_err <= 1'b0;
      else if ((wea && !a_ok) || (enb && !b_ok)) addr_err <= 1'b1;

endmodule

// File: tb/tb_bram_sdp_pipe.sv
// tb_bram_sdp_pipe: random and directed stimulus on three configurations checked against a word-array model
module tb_bram_sdp_pipe;

   localparam int W  = 18;
   localparam int AW = 10;
   localparam int ND = 3;
`ifdef BRAM_WRITE_FIRST_EN
   localparam bit WF = 1'b1;
`else
   localparam bit WF = 1'b0;
`endif

   logic          clk = 1'b0, rsta_n = 1'b1, wea = 1'b0, enb = 1'b0;
   logic [AW-1:0] addra = '0, addrb = '0;
   logic [W-1:0]  dina = '0;
   logic [W-1:0]  doutb [ND];
   logic          vld [ND], err [ND];

   int nchk = 0, nerr = 0, cyc = 0, vrun = 0;

   logic [W-1:0] mm [ND][1024];
   bit           sv [ND][8];
   logic [W-1:0] sd [ND][8];
   logic [W-1:0] last [ND];
   bit           merr [ND];

   always #5 clk = ~clk;

   bram_sdp_pipe #(.RAM_WIDTH(W), .RAM_DEPTH(1024), .RD_LATENCY(2)) u_dut0 (
      .clka(clk), .rsta_n(rsta_n), .wea(wea), .addra(addra), .dina(dina), .enb(enb), .addrb(addrb),
      .doutb(doutb[0]), .doutb_valid(vld[0]), .addr_err(err[0]));
   bram_sdp_pipe #(.RAM_WIDTH(W), .RAM_DEPTH(1000), .RD_LATENCY(4)) u_dut1 (
      .clka(clk), .rsta_n(rsta_n), .wea(wea), .addra(addra), .dina(dina), .enb(enb), .addrb(addrb),
      .doutb(doutb[1]), .doutb_valid(vld[1]), .addr_err(err[1]));
   bram_sdp_pipe #(.RAM_WIDTH(W), .RAM_DEPTH(1024), .RD_LATENCY(1)) u_dut2 (
      .clka(clk), .rsta_n(rsta_n), .wea(wea), .addra(addra), .dina(dina), .enb(enb), .addrb(addrb),
      .doutb(doutb[2]), .doutb_valid(vld[2]), .addr_err(err[2]));

   function automatic int dep(input int d);
      return (d == 1) ? 1000 : 1024;
   endfunction

   function automatic int lat(input int d);
      return (d == 0) ? 2 : (d == 1) ? 4 : 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Apply one clock edge to the model and DUTs, then compare every output
   task automatic step();
      int s;
      logic [W-1:0] r;
      if (rsta_n) begin
         for (int d = 0; d < ND; d++) begin
            if (enb) begin
               if (int'(addrb) >= dep(d)) r = '0;
               else if (WF && wea && addra == addrb) r = dina;
               else r = mm[d][addrb];
               s = (cyc + lat(d)) % 8;
               sv[d][s] = 1'b1;
               sd[d][s] = r;
            end
            if ((wea && int'(addra) >= dep(d)) || (enb && int'(addrb) >= dep(d))) merr[d] = 1'b1;
            if (wea && int'(addra) < dep(d)) mm[d][addra] = dina;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (vld[0]) vrun++;
      for (int d = 0; d < ND; d++) begin
         s = cyc % 8;
         if (sv[d][s]) last[d] = sd[d][s];
         check($sformatf("valid%0d", d), 32'(vld[d]), 32'(sv[d][s]));
         check($sformatf("dout%0d", d), 32'(doutb[d]), 32'(last[d]));
         check($sformatf("err%0d", d), 32'(err[d]), 32'(merr[d]));
         sv[d][s] = 1'b0;
      end
   endtask

   task automatic do_reset();
      #1 rsta_n = 1'b0;
      #1;
      wea = 1'b0;
      enb = 1'b0;
      for (int d = 0; d < ND; d++) begin
         for (int s = 0; s < 8; s++) sv[d][s] = 1'b0;
         last[d] = '0;
         merr[d] = 1'b0;
         check($sformatf("rst_dout%0d", d), 32'(doutb[d]), 32'd0);
         check($sformatf("rst_valid%0d", d), 32'(vld[d]), 32'd0);
         check($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
      end
      step();
      step();
      rsta_n = 1'b1;
   endtask

   task automatic wr(input int a, input int v);
      wea = 1'b1; addra = AW'(a); dina = W'(v); enb = 1'b0;
      step();
      wea = 1'b0;
   endtask

   task automatic rd(input int a);
      enb = 1'b1; addrb = AW'(a); wea = 1'b0;
      step();
      enb = 1'b0;
   endtask

   task automatic idle(input int n);
      wea = 1'b0; enb = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 1024; i++) mm[d][i] = '0;
         last[d] = '0;
         merr[d] = 1'b0;
      end
      do_reset();
      for (int i = 0; i < 1024; i++) begin
         wea = 1'b1; addra = AW'(i); dina = W'(i);
         step();
      end
      wea = 1'b0;
      vrun = 0;
      for (int i = 0; i < 1024; i++) begin
         enb = 1'b1; addrb = AW'(i);
         step();
      end
      idle(5);
      check("readback_run", 32'(vrun), 32'd1024);
      rd(10); rd(11); rd(12);
      do_reset();
      idle(6);
      rd(10); rd(11); rd(12);
      idle(5);
      wr(5, 'h00AA);
      wea = 1'b1; enb = 1'b1; addra = AW'(5); addrb = AW'(5); dina = W'('h3FFFF);
      step();
      idle(5);
      rd(5);
      idle(5);
      wr(7, 'h1234);
      rd(7);
      idle(6);
      wr(9, 'h0042);
      rd(9);
      idle(10);
      wr(1010, 'h155);
      rd(1010);
      idle(5);
      rd(3);
      idle(8);
      for (int i = 0; i < 400; i++) begin
         wea = 1'($urandom);
         enb = 1'($urandom);
         addra = AW'($urandom_range(0, 1023));
         addrb = ($urandom_range(0, 3) == 0) ? addra : AW'($urandom_range(0, 1023));
         dina = W'($urandom);
         step();
      end
      idle(6);
      do_reset();
      idle(3);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
